// File: rtl/alu_iter.sv
// alu_iter: execute-stage ALU with single-cycle logic/arith/compare ops and bit-serial shifts behind valid/ready handshakes.
module alu_iter #(
    parameter int DATA_WIDTH = 32,
    parameter int SHAMT_W    = $clog2(DATA_WIDTH)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [3:0]            Operation,
    input  logic [DATA_WIDTH-1:0] SrcA,
    input  logic [DATA_WIDTH-1:0] SrcB,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] ALUResult,
    output logic                  Zero
);
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t                state, state_n;
    logic [SHAMT_W-1:0]    cnt, cnt_n;
    logic [DATA_WIDTH-1:0] work, work_n, step, comb_res, res_n;
    logic [1:0]            sh_op, sh_op_n;
    logic                  accept, is_shift, load;
    logic [SHAMT_W-1:0]    shamt;

    assign in_ready  = !reset && !flush && (state == IDLE || (state == DONE && out_ready));
    assign accept    = in_valid && in_ready;
    assign out_valid = (state == DONE);
    assign shamt     = SrcB[SHAMT_W-1:0];
    assign is_shift  = (Operation[3:2] == 2'b01) && (Operation[1:0] != 2'b00);

    always_comb begin
        case (Operation)
            4'b0000: comb_res = SrcA & SrcB;
            4'b0001: comb_res = SrcA | SrcB;
            4'b0010: comb_res = SrcA + SrcB;
            4'b0011: comb_res = SrcA - SrcB;
            4'b0100: comb_res = SrcA ^ SrcB;
            4'b0101, 4'b0110, 4'b0111: comb_res = SrcA;
            4'b1000: comb_res = DATA_WIDTH'(SrcA == SrcB);
            4'b1100: comb_res = DATA_WIDTH'($signed(SrcA) < $signed(SrcB));
            default: comb_res = '0;
        endcase
    end

    // sh_op holds Operation[1:0]: 01 SRL, 10 SLL, 11 SRA
    assign step = (sh_op == 2'b01) ? work >> 1 :
                  (sh_op == 2'b10) ? work << 1 :
                  {work[DATA_WIDTH-1], work[DATA_WIDTH-1:1]};

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        work_n  = work;
        sh_op_n = sh_op;
        load    = 1'b0;
        res_n   = comb_res;
        if (flush) begin
            state_n = IDLE;
            cnt_n   = '0;
        end else if (accept) begin
            if (is_shift && shamt != '0) begin
                state_n = SHIFT;
                work_n  = SrcA;
                cnt_n   = shamt;
                sh_op_n = Operation[1:0];
            end else begin
                state_n = DONE;
                load    = 1'b1;
            end
        end else if (state == SHIFT) begin
            work_n = step;
            cnt_n  = cnt - SHAMT_W'(1);
            if (cnt == SHAMT_W'(1)) begin
                state_n = DONE;
                load    = 1'b1;
                res_n   = step;
            end
        end else if (state == DONE && out_ready) begin
            state_n = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            work      <= '0;
            sh_op     <= '0;
            ALUResult <= '0;
            Zero      <= 1'b0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            work  <= work_n;
            sh_op <= sh_op_n;
            if (load) begin
                ALUResult <= res_n;
                Zero      <= (res_n == '0);
            end
        end
    end
endmodule

// File: tb/tb_alu_iter.sv
// tb_alu_iter: directed-vector checks of alu_iter ops, shift latency, backpressure, flush and reset.
module tb_alu_iter;
    localparam int W = 32;

    logic         clk = 0, reset = 0, flush = 0, in_valid = 0, out_ready = 0;
    logic [3:0]   Operation = '0;
    logic [W-1:0] SrcA = '0, SrcB = '0;
    logic         in_ready, out_valid, Zero;
    logic [W-1:0] ALUResult;
    int           checks = 0, errors = 0;

    alu_iter #(.DATA_WIDTH(W)) dut (
        .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .Operation(Operation), .SrcA(SrcA), .SrcB(SrcB), .out_valid(out_valid),
        .out_ready(out_ready), .ALUResult(ALUResult), .Zero(Zero)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        Operation = op;
        SrcA      = a;
        SrcB      = b;
        in_valid  = 1;
    endtask

    task automatic test_reset();
        reset = 1;
        out_ready = 1;
        drive(4'b0010, 32'd1, 32'd1);
        for (int i = 0; i < 2; i++) begin
            cyc();
            checks++;
            if (out_valid !== 1'b0 || ALUResult !== '0 || Zero !== 1'b0 || in_ready !== 1'b0) begin
                errors++;
                $display("FAIL reset_values got ov=%b res=%h z=%b ir=%b required 0 0 0 0", out_valid, ALUResult, Zero, in_ready);
            end
        end
        reset = 0;
        in_valid = 0;
        #1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_release got ir=%b ov=%b required 1 0", in_ready, out_valid);
        end
        cyc();
    endtask

    task automatic test_single();
        logic [3:0]   ops [4] = '{4'b0010, 4'b0011, 4'b1100, 4'b1000};
        logic [W-1:0] as  [4] = '{32'h7FFF_FFFF, 32'd5, 32'hFFFF_FFFF, 32'hA5A5_A5A5};
        logic [W-1:0] bs  [4] = '{32'd1, 32'd5, 32'd1, 32'hA5A5_A5A5};
        logic [W-1:0] exp [4] = '{32'h8000_0000, 32'd0, 32'd1, 32'd1};
        out_ready = 1;
        for (int i = 0; i < 4; i++) begin
            drive(ops[i], as[i], bs[i]);
            #1;
            checks++;
            if (in_ready !== 1'b1) begin
                errors++;
                $display("FAIL single_ready[%0d] got %b required 1", i, in_ready);
            end
            cyc();
            checks++;
            if (out_valid !== 1'b1 || ALUResult !== exp[i] || Zero !== (exp[i] == '0)) begin
                errors++;
                $display("FAIL single_op[%0d] got ov=%b res=%h z=%b required 1 %h %b", i, out_valid, ALUResult, Zero, exp[i], exp[i] == '0);
            end
        end
        in_valid = 0;
        cyc();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL single_drain got ov=%b required 0", out_valid);
        end
    endtask

    task automatic run_shift(input string name, input logic [3:0] op, input logic [W-1:0] a,
                             input logic [W-1:0] b, input int n, input logic [W-1:0] exp);
        out_ready = 1;
        drive(op, a, b);
        cyc();
        in_valid = 0;
        for (int k = 1; k <= n; k++) begin
            #1;
            checks++;
            if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
                errors++;
                $display("FAIL %s_busy cycle %0d got ov=%b ir=%b required 0 0", name, k, out_valid, in_ready);
            end
            cyc();
        end
        checks++;
        if (out_valid !== 1'b1 || ALUResult !== exp || Zero !== (exp == '0)) begin
            errors++;
            $display("FAIL %s_result got ov=%b res=%h z=%b required 1 %h", name, out_valid, ALUResult, Zero, exp);
        end
        cyc();
    endtask

    task automatic test_shift();
        run_shift("sra4", 4'b0111, 32'h8000_0000, 32'd4, 4, 32'hF800_0000);
        run_shift("srl4", 4'b0101, 32'h8000_0000, 32'd4, 4, 32'h0800_0000);
        run_shift("sll31", 4'b0110, 32'd1, 32'd31, 31, 32'h8000_0000);
        run_shift("sll0", 4'b0110, 32'h1234_5678, 32'h20, 0, 32'h1234_5678);
    endtask

    task automatic test_backpressure();
        out_ready = 0;
        drive(4'b0010, 32'd10, 32'd20);
        cyc();
        drive(4'b0100, 32'h0000_F0F0, 32'h0000_0FF0);
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (out_valid !== 1'b1 || ALUResult !== 32'd30 || in_ready !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold[%0d] got ov=%b res=%h ir=%b required 1 0000001e 0", i, out_valid, ALUResult, in_ready);
            end
            cyc();
        end
        out_ready = 1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_release_ready got %b required 1", in_ready);
        end
        cyc();
        in_valid = 0;
        checks++;
        if (out_valid !== 1'b1 || ALUResult !== 32'h0000_FF00) begin
            errors++;
            $display("FAIL bp_next got ov=%b res=%h required 1 0000ff00", out_valid, ALUResult);
        end
        cyc();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL bp_no_dup got ov=%b required 0", out_valid);
        end
    endtask

    task automatic test_flush();
        out_ready = 1;
        drive(4'b0110, 32'd1, 32'd20);
        cyc();
        in_valid = 0;
        for (int k = 1; k < 5; k++) begin
            checks++;
            if (out_valid !== 1'b0) begin
                errors++;
                $display("FAIL flush_pre[%0d] got ov=%b required 0", k, out_valid);
            end
            cyc();
        end
        flush = 1;
        drive(4'b0010, 32'd2, 32'd3);
        #1;
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL flush_ready got %b required 0", in_ready);
        end
        cyc();
        flush = 0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || ALUResult !== 32'h0000_FF00) begin
            errors++;
            $display("FAIL flush_idle got ov=%b ir=%b res=%h required 0 1 0000ff00", out_valid, in_ready, ALUResult);
        end
        cyc();
        in_valid = 0;
        checks++;
        if (out_valid !== 1'b1 || ALUResult !== 32'd5 || Zero !== 1'b0) begin
            errors++;
            $display("FAIL flush_add got ov=%b res=%h z=%b required 1 00000005 0", out_valid, ALUResult, Zero);
        end
        cyc();
    endtask

    task automatic test_illegal();
        out_ready = 1;
        drive(4'b1111, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        cyc();
        in_valid = 0;
        checks++;
        if (out_valid !== 1'b1 || ALUResult !== 32'd0 || Zero !== 1'b1) begin
            errors++;
            $display("FAIL illegal got ov=%b res=%h z=%b required 1 00000000 1", out_valid, ALUResult, Zero);
        end
        cyc();
    endtask

    task automatic test_reset_mid_shift();
        out_ready = 1;
        drive(4'b0010, 32'd7, 32'd0);
        cyc();
        drive(4'b0111, 32'h8000_0000, 32'd10);
        cyc();
        in_valid = 0;
        cyc();
        cyc();
        reset = 1;
        cyc();
        reset = 0;
        for (int k = 0; k < 12; k++) begin
            checks++;
            if (out_valid !== 1'b0 || ALUResult !== '0 || Zero !== 1'b0) begin
                errors++;
                $display("FAIL reset_mid[%0d] got ov=%b res=%h z=%b required 0 0 0", k, out_valid, ALUResult, Zero);
            end
            cyc();
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_shift();
        test_backpressure();
        test_flush();
        test_illegal();
        test_reset_mid_shift();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
